// File: rtl/fb_rect_if.sv
// fb_rect_if: request handshake and BRAM write port of the frame-buffer
// rectangle writer, grouped into one bundle.
//   master : side issuing fill requests and owning the BRAM (drives req_*, wr_stall)
//   slave  : the fill engine (drives req_ready, wr_*, busy, done, err)
// Signals:
//   req_valid/req_ready      request handshake
//   req_x/req_y/req_w/req_h  rectangle origin and size in pixels
//   req_color                fill colour (4:4:4 RGB)
//   wr_stall                 BRAM write port unavailable this cycle
//   wr_en/wr_addr/wr_data    BRAM write port
//   busy/done/err            engine status; done and err are one-cycle pulses
interface fb_rect_if #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 12
);
  logic              req_valid;
  logic              req_ready;
  logic [7:0]        req_x;
  logic [6:0]        req_y;
  logic [7:0]        req_w;
  logic [6:0]        req_h;
  logic [DATA_W-1:0] req_color;
  logic              wr_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output req_valid, req_x, req_y, req_w, req_h, req_color, wr_stall,
    input  req_ready, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    input  req_valid, req_x, req_y, req_w, req_h, req_color, wr_stall,
    output req_ready, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/fb_rect_writer.sv
// fb_rect_writer: fills a rectangle of the 160x120 frame buffer, one pixel
// write per cycle in row-major order, for the game's drawing logic.
// Ports:
//   clk  system clock
//   rst  synchronous, active-high reset
//   bus  fb_rect_if.slave: request handshake, BRAM write port, busy/done/err
// Build option:
//   FB_CLIP_EN  defined   -> requests are clipped to the frame buffer, err never set
//               undefined -> a request reaching past the frame buffer is rejected
//                            (done+err, no writes)
//
// state | meaning
// IDLE  | waiting for a request, req_ready high
// FILL  | issuing pixel writes, one per non-stalled cycle
// DONE  | one cycle: done pulse (with err if the request was rejected)
module fb_rect_writer #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 12
) (
  input logic     clk,
  input logic     rst,
  fb_rect_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  localparam logic [8:0]        W9     = 9'(IMG_WIDTH);
  localparam logic [8:0]        H9     = 9'(IMG_HEIGHT);
  localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(IMG_WIDTH);

  state_t            state;
  logic [7:0]        x_q;
  logic [8:0]        w_q, h_q, col_q, row_q;
  logic [DATA_W-1:0] color_q;
  logic [ADDR_W-1:0] row_base_q;
  logic              err_q;

  logic [8:0]        x_ext, y_ext, w_ext, h_ext, w_eff_c, h_eff_c;
  logic              zero_c, oob_c;
  logic [ADDR_W-1:0] y_a, row_base_c, addr_c;

  // Request decode, only consumed in the accept cycle.
  always_comb begin
    x_ext   = {1'b0, bus.req_x};
    y_ext   = {2'b0, bus.req_y};
    w_ext   = {1'b0, bus.req_w};
    h_ext   = {2'b0, bus.req_h};
    w_eff_c = w_ext;
    h_eff_c = h_ext;
    zero_c  = 1'b0;
    oob_c   = 1'b0;
`ifdef FB_CLIP_EN
    if (x_ext >= W9 || y_ext >= H9) begin
      zero_c = 1'b1;
    end else begin
      if (w_ext > W9 - x_ext) w_eff_c = W9 - x_ext;
      if (h_ext > H9 - y_ext) h_eff_c = H9 - y_ext;
    end
    if (w_eff_c == 9'd0 || h_eff_c == 9'd0) zero_c = 1'b1;
`else
    // An empty rectangle completes cleanly even if its origin is off-screen.
    zero_c = (w_ext == 9'd0) || (h_ext == 9'd0);
    oob_c  = !zero_c && ((x_ext + w_ext > W9) || (y_ext + h_ext > H9));
`endif
    y_a = ADDR_W'(bus.req_y);
    if (IMG_WIDTH == 160) row_base_c = (y_a << 7) + (y_a << 5);
    else                  row_base_c = y_a * STRIDE;
  end

  assign addr_c = row_base_q + ADDR_W'(x_q) + ADDR_W'(col_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            x_q        <= bus.req_x;
            w_q        <= w_eff_c;
            h_q        <= h_eff_c;
            color_q    <= bus.req_color;
            row_base_q <= row_base_c;
            col_q      <= 9'd0;
            row_q      <= 9'd0;
            if (zero_c || oob_c) begin
              state <= DONE;
              err_q <= oob_c;
            end else begin
              state <= FILL;
            end
          end
        end
        FILL: begin
          // A stalled cycle writes nothing, so the position holds.
          if (!bus.wr_stall) begin
            if (col_q == w_q - 9'd1) begin
              col_q <= 9'd0;
              if (row_q == h_q - 9'd1) begin
                state <= DONE;
              end else begin
                row_q      <= row_q + 9'd1;
                row_base_q <= row_base_q + STRIDE;
              end
            end else begin
              col_q <= col_q + 9'd1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          err_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are gated by rst so a reset during FILL stops writes in that same cycle.
  assign bus.req_ready = (state == IDLE) && !rst;
  assign bus.wr_en     = (state == FILL) && !bus.wr_stall && !rst;
  assign bus.wr_addr   = ((state == FILL) && !rst) ? addr_c  : '0;
  assign bus.wr_data   = ((state == FILL) && !rst) ? color_q : '0;
  assign bus.busy      = (state != IDLE) && !rst;
  assign bus.done      = (state == DONE) && !rst;
  assign bus.err       = (state == DONE) && !rst && err_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
module tb_fb_rect_writer;
  localparam int IMG_WIDTH  = 160;
  localparam int IMG_HEIGHT = 120;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_rect_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_rect_writer #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT),
    .ADDR_W(ADDR_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: the list of pixel addresses a request must produce, and whether it is rejected.
  task automatic model(input int x, input int y, input int w, input int h);
    int we, he;
    exp_q.delete();
    exp_err = 1'b0;
`ifdef FB_CLIP_EN
    if (x >= IMG_WIDTH || y >= IMG_HEIGHT) begin
      we = 0; he = 0;
    end else begin
      we = (w < IMG_WIDTH - x)  ? w : IMG_WIDTH - x;
      he = (h < IMG_HEIGHT - y) ? h : IMG_HEIGHT - y;
    end
`else
    we = w; he = h;
    if (w != 0 && h != 0 && (x + w > IMG_WIDTH || y + h > IMG_HEIGHT)) begin
      exp_err = 1'b1; we = 0; he = 0;
    end
`endif
    for (int r = 0; r < he; r++)
      for (int c = 0; c < we; c++)
        exp_q.push_back((y + r) * IMG_WIDTH + x + c);
  endtask

  // One transaction; stall_mask bit k stalls cycle T+1+k, abort_after>=0 resets after that many writes.
  task automatic do_req(input int x, input int y, input int w, input int h,
                        input logic [11:0] color, input logic [31:0] stall_mask,
                        input int stall_pct, input int abort_after, input string tag);
    int k = 0;
    int nwr = 0;
    bit stall;
    model(x, y, w, h);
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_x = 8'(x); bus.req_y = 7'(y); bus.req_w = 8'(w); bus.req_h = 7'(h);
    bus.req_color = color;
    bus.wr_stall = 1'b0;
    #1;
    check({tag, " ready_at_accept"}, bus.req_ready, 1);
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      if (abort_after >= 0 && nwr == abort_after) begin
        rst = 1'b1; bus.req_valid = 1'b0; bus.wr_stall = 1'b0;
        #1;
        check({tag, " rst_wr_en"}, bus.wr_en, 0);
        check({tag, " rst_busy"},  bus.busy, 0);
        check({tag, " rst_ready"}, bus.req_ready, 0);
        check({tag, " rst_done"},  bus.done, 0);
        @(posedge clk); #1;
        check({tag, " rst_wr_en2"}, bus.wr_en, 0);
        rst = 1'b0;
        #1;
        check({tag, " ready_after_rst"}, bus.req_ready, 1);
        check({tag, " wr_en_after_rst"}, bus.wr_en, 0);
        check({tag, " done_after_rst"},  bus.done, 0);
        exp_q.delete();
        return;
      end
      stall = (k < 32 && stall_mask[k]) || ($urandom_range(99) < stall_pct);
      bus.wr_stall  = stall;
      bus.req_valid = 1'($urandom_range(1));
      bus.req_x = 8'($urandom); bus.req_y = 7'($urandom);
      bus.req_w = 8'($urandom); bus.req_h = 7'($urandom);
      bus.req_color = 12'($urandom);
      #1;
      check({tag, " wr_en"},   bus.wr_en, !stall);
      check({tag, " wr_addr"}, bus.wr_addr, exp_q[0]);
      check({tag, " wr_data"}, bus.wr_data, color);
      check({tag, " done_early"}, bus.done, 0);
      if (!stall) begin
        void'(exp_q.pop_front());
        nwr++;
      end
      k++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    bus.wr_stall  = 1'($urandom_range(1));
    #1;
    check({tag, " done"},      bus.done, 1);
    check({tag, " err"},       bus.err, exp_err);
    check({tag, " done_wr_en"}, bus.wr_en, 0);
    check({tag, " done_addr"}, bus.wr_addr, 0);
    check({tag, " done_data"}, bus.wr_data, 0);
    check({tag, " done_busy"}, bus.busy, 1);
    check({tag, " done_ready"}, bus.req_ready, 0);
    @(posedge clk); #1;
    bus.wr_stall = 1'b0;
    #1;
    check({tag, " ready_again"}, bus.req_ready, 1);
    check({tag, " idle_busy"},   bus.busy, 0);
    check({tag, " idle_done"},   bus.done, 0);
    check({tag, " idle_err"},    bus.err, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    bus.req_valid = 1'b0;
    bus.req_x = '0; bus.req_y = '0; bus.req_w = '0; bus.req_h = '0;
    bus.req_color = '0;
    bus.wr_stall = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset ready",   bus.req_ready, 0);
    check("reset wr_en",   bus.wr_en, 0);
    check("reset wr_addr", bus.wr_addr, 0);
    check("reset wr_data", bus.wr_data, 0);
    check("reset busy",    bus.busy, 0);
    check("reset done",    bus.done, 0);
    check("reset err",     bus.err, 0);
    rst = 1'b0;

    do_req(0, 0, 2, 2, 12'hF00, 32'h0, 0, -1, "t1_2x2");
    do_req(10, 5, 3, 1, 12'h0A5, 32'h2, 0, -1, "t2_stall");
    do_req(77, 33, 0, 9, 12'h123, 32'h0, 0, -1, "t3_w0");
    do_req(200, 127, 0, 4, 12'h456, 32'h0, 0, -1, "t3_w0_far");
    do_req(5, 6, 7, 0, 12'h789, 32'h0, 0, -1, "t3_h0");
    do_req(158, 119, 4, 1, 12'h00F, 32'h0, 0, -1, "t4_edge");
    do_req(170, 10, 3, 3, 12'h0F0, 32'h0, 0, -1, "t4_x_off");
    do_req(0, 0, 10, 10, 12'hABC, 32'h0, 0, 5, "t5_reset");
    do_req(0, 0, 1, 1, 12'hDEF, 32'h0, 0, -1, "t5_after");
    do_req(150, 100, 10, 20, 12'h321, 32'h15, 0, -1, "exact_corner");

    for (int i = 0; i < 25; i++) begin
      do_req($urandom_range(0, 175), $urandom_range(0, 127),
             $urandom_range(0, 24), $urandom_range(0, 16),
             12'($urandom), $urandom, $urandom_range(0, 40), -1, "rand");
    end

    do_req(0, 0, 160, 120, 12'h5A5, 32'h0, 0, -1, "t6_full");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
